dc_huffman_encoder: RTL and testbench

Bit-serial JPEG DC entropy encoder, the transmit-side counterpart of the bit-serial DC Huffman decode table.
- Accepts one DC symbol per transaction: a category (SSSS, 0..11) plus its amplitude bits.
- Emits the standard luminance DC Huffman code MSB-first, then the category's amplitude bits MSB-first, one bit per accepted cycle.
- Sits between the DC differential/quantisation stage and the bitstream packer.

---
 rtl/dc_huffman_encoder.sv | 133 +++++++++++++
 tb/tb_dc_huffman_encoder.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/dc_huffman_encoder.sv
// Bit-serial JPEG luminance DC Huffman encoder.
// Emits code MSB-first, then category amplitude bits MSB-first.
module dc_huffman_encoder #(
  parameter int AMP_W   = 11,
  parameter int MAX_CAT = 11
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       category,
  input  logic [AMP_W-1:0] amplitude,
  output logic             bit_out,
  output logic             bit_valid,
  input  logic             bit_ready,
  output logic             bit_last,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE,
    CODE,
    AMP
  } state_t;

  localparam logic [3:0] MAX_C = 4'(MAX_CAT);

  state_t           state;
  state_t           state_nx;
  logic [8:0]       sr;
  logic [3:0]       cnt;
  logic [3:0]       cat_q;
  logic [3:0]       idx;
  logic [AMP_W-1:0] amp_q;
  logic             err_q;
  logic [8:0]       lut_code;
  logic [3:0]       lut_len;
  logic             legal;
  logic             accept;
  logic             xfer;

  // Standard luminance DC table, code left-aligned in 9 bits.
  always_comb begin
    lut_code = 9'b0;
    lut_len  = 4'd2;
    case (category)
      4'd0:    begin lut_code = 9'b000000000; lut_len = 4'd2; end
      4'd1:    begin lut_code = 9'b010000000; lut_len = 4'd3; end
      4'd2:    begin lut_code = 9'b011000000; lut_len = 4'd3; end
      4'd3:    begin lut_code = 9'b100000000; lut_len = 4'd3; end
      4'd4:    begin lut_code = 9'b101000000; lut_len = 4'd3; end
      4'd5:    begin lut_code = 9'b110000000; lut_len = 4'd3; end
      4'd6:    begin lut_code = 9'b111000000; lut_len = 4'd4; end
      4'd7:    begin lut_code = 9'b111100000; lut_len = 4'd5; end
      4'd8:    begin lut_code = 9'b111110000; lut_len = 4'd6; end
      4'd9:    begin lut_code = 9'b111111000; lut_len = 4'd7; end
      4'd10:   begin lut_code = 9'b111111100; lut_len = 4'd8; end
      4'd11:   begin lut_code = 9'b111111110; lut_len = 4'd9; end
      default: begin lut_code = 9'b0;        lut_len = 4'd2; end
    endcase
  end

  assign legal  = (category <= MAX_C);
  assign accept = in_valid && (state == IDLE);
  assign xfer   = bit_valid && bit_ready;
  assign err    = err_q;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  // Next-state and serial outputs from registered state.
  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    bit_valid = 1'b0;
    bit_out   = 1'b0;
    bit_last  = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid && legal) state_nx = CODE;
      end
      CODE: begin
        bit_valid = 1'b1;
        bit_out   = sr[8];
        bit_last  = (cnt == 4'd1) && (cat_q == 4'd0);
        if (bit_ready && cnt == 4'd1)
          state_nx = (cat_q == 4'd0) ? IDLE : AMP;
      end
      AMP: begin
        bit_valid = 1'b1;
        bit_out   = amp_q[idx];
        bit_last  = (idx == 4'd0);
        if (bit_ready && idx == 4'd0) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Symbol latch, code shifter, amplitude index, error pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr    <= '0;
      cnt   <= '0;
      cat_q <= '0;
      idx   <= '0;
      amp_q <= '0;
      err_q <= 1'b0;
    end else begin
      err_q <= 1'b0;
      if (accept) begin
        if (legal) begin
          sr    <= lut_code;
          cnt   <= lut_len;
          cat_q <= category;
          amp_q <= amplitude;
          idx   <= (category == 4'd0) ? 4'd0 : 4'(category - 4'd1);
        end else begin
          err_q <= 1'b1;
        end
      end else if (xfer && state == CODE) begin
        sr  <= {sr[7:0], 1'b0};
        cnt <= cnt - 4'd1;
      end else if (xfer && state == AMP) begin
        if (idx != 4'd0) idx <= idx - 4'd1;
      end
    end
  end

endmodule

// File: tb/tb_dc_huffman_encoder.sv
// Self-checking bench for dc_huffman_encoder.
// Table vectors plus scoreboard of expected serial bits.
module tb_dc_huffman_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  category;
  logic [10:0] amplitude;
  logic        bit_out;
  logic        bit_valid;
  logic        bit_ready;
  logic        bit_last;
  logic        err;

  int tests = 0;
  int fails = 0;
  int popped = 0;
  int mode = 0;
  int k = 0;

  logic [1:0] q[$];

  typedef struct {
    logic [3:0]  cat;
    logic [10:0] amp;
    int          n;
    logic [19:0] exp;
  } vec_t;

  vec_t tbl[12];

  dc_huffman_encoder #(.AMP_W(11), .MAX_CAT(11)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .category  (category),
    .amplitude (amplitude),
    .bit_out   (bit_out),
    .bit_valid (bit_valid),
    .bit_ready (bit_ready),
    .bit_last  (bit_last),
    .err       (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  // bit_ready driver: 0 = always, 1 = 1,0,0,1,0,1 pattern, 2 = random
  initial begin
    logic [5:0] pat;
    pat = 6'b100101;
    bit_ready = 1'b1;
    forever begin
      @(posedge clk);
      #2;
      case (mode)
        1:       bit_ready = pat[5 - (k % 6)];
        2:       bit_ready = 1'($urandom_range(0, 1));
        default: bit_ready = 1'b1;
      endcase
      k++;
    end
  end

  // Scoreboard consumer and stall-stability checker.
  initial begin
    logic ps;
    logic pb;
    logic pl;
    logic [1:0] e;
    ps = 1'b0;
    pb = 1'b0;
    pl = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_n && ps) begin
        tests++;
        if (!bit_valid || bit_out !== pb || bit_last !== pl) begin
          fails++;
          $display("FAIL stall_hold: got v%b b%b l%b expected v1 b%b l%b",
                   bit_valid, bit_out, bit_last, pb, pl);
        end
      end
      if (rst_n && bit_valid && bit_ready) begin
        tests++;
        popped++;
        if (q.size() == 0) begin
          fails++;
          $display("FAIL extra_bit: got b%b l%b expected none",
                   bit_out, bit_last);
        end else begin
          e = q.pop_front();
          if ({bit_out, bit_last} !== e) begin
            fails++;
            $display("FAIL bit: got b%b l%b expected b%b l%b",
                     bit_out, bit_last, e[1], e[0]);
          end
        end
      end
      ps = rst_n && bit_valid && !bit_ready;
      pb = bit_out;
      pl = bit_last;
    end
  end

  task automatic push_bits(input int n, input logic [19:0] e);
    for (int i = 0; i < n; i++)
      q.push_back({e[19 - i], (i == n - 1)});
  endtask

  task automatic send(input logic [3:0] c, input logic [10:0] a,
                      input int n, input logic [19:0] e);
    int cyc;
    k = 0;
    popped = 0;
    push_bits(n, e);
    in_valid  = 1'b1;
    category  = c;
    amplitude = a;
    @(posedge clk);
    #1;
    in_valid  = 1'b0;
    category  = 4'($urandom_range(0, 15));
    amplitude = 11'($urandom);
    chk("latency_valid", 32'(bit_valid), 32'd1);
    chk("busy_ready", 32'(in_ready), 32'd0);
    cyc = 0;
    while (!in_ready && cyc < 400) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (cyc >= 400) begin
      tests++;
      fails++;
      $display("FAIL timeout: got %0d cycles expected < 400", cyc);
    end
    chk("bit_count", 32'(popped), 32'(n));
    chk("queue_empty", 32'(q.size()), 32'd0);
    if (mode == 0) chk("throughput", 32'(cyc), 32'(n));
    q.delete();
  endtask

  initial begin
    tbl[0]  = '{4'd0,  11'h000, 2,  20'b00 << 18};
    tbl[1]  = '{4'd3,  11'h005, 6,  20'b100101 << 14};
    tbl[2]  = '{4'd11, 11'h7FF, 20, 20'hFF7FF};
    tbl[3]  = '{4'd5,  11'h00D, 8,  20'b11001101 << 12};
    tbl[4]  = '{4'd1,  11'h001, 4,  20'b0101 << 16};
    tbl[5]  = '{4'd2,  11'h002, 5,  20'b01110 << 15};
    tbl[6]  = '{4'd6,  11'h7E3, 10, 20'b1110100011 << 10};
    tbl[7]  = '{4'd7,  11'h000, 12, 20'b111100000000 << 8};
    tbl[8]  = '{4'd8,  11'h0A5, 14, 20'b11111010100101 << 6};
    tbl[9]  = '{4'd9,  11'h155, 16, 20'b1111110101010101 << 4};
    tbl[10] = '{4'd10, 11'h001, 18, 20'b111111100000000001 << 2};
    tbl[11] = '{4'd4,  11'h7F6, 7,  20'b1010110 << 13};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    category  = '0;
    amplitude = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_bit_valid", 32'(bit_valid), 32'd0);
    chk("rst_bit_out", 32'(bit_out), 32'd0);
    chk("rst_bit_last", 32'(bit_last), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    mode = 0;
    for (int i = 0; i < 12; i++)
      send(tbl[i].cat, tbl[i].amp, tbl[i].n, tbl[i].exp);

    mode = 1;
    send(4'd5, 11'h00D, 8, 20'b11001101 << 12);

    mode = 2;
    for (int i = 0; i < 12; i++)
      send(tbl[i].cat, tbl[i].amp, tbl[i].n, tbl[i].exp);
    mode = 0;
    @(posedge clk);
    #1;

    in_valid  = 1'b1;
    category  = 4'd13;
    amplitude = 11'h7FF;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    chk("err_pulse", 32'(err), 32'd1);
    chk("err_no_valid", 32'(bit_valid), 32'd0);
    chk("err_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    chk("err_one_cycle", 32'(err), 32'd0);
    chk("err_no_valid2", 32'(bit_valid), 32'd0);
    send(4'd1, 11'h001, 4, 20'b0101 << 16);

    q.delete();
    push_bits(2, 20'b10 << 18);
    q[1] = {1'b0, 1'b0};
    in_valid  = 1'b1;
    category  = 4'd4;
    amplitude = 11'h00F;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_valid", 32'(bit_valid), 32'd0);
    chk("mid_rst_ready", 32'(in_ready), 32'd1);
    chk("mid_rst_last", 32'(bit_last), 32'd0);
    chk("mid_rst_bits", 32'(q.size()), 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    q.delete();
    @(posedge clk);
    #1;
    send(4'd2, 11'h002, 5, 20'b01110 << 15);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
